nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit additions by reusing a single 4-bit ripple-carry adder stage (four full-adder cells) once per nibble, least significant nibble first.
- Latches operands through a valid/ready input handshake.
- Steps the nibble index while registering the inter-nibble carry.
- Presents the result through a valid/ready output handshake.
- Sits between switch/register sources and display/accumulator logic where a wide combinational adder is not wanted.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. Build-time error otherwise.
- NIB (derived, not overridable), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and c_in are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- c_in  input  1  carry into nibble 0.
- out_valid  output  1  sum/c_out are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, registered.
- c_out  output  1  carry out of the top nibble, registered.
- busy  output  1  high in ADD state.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum=0, c_out=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset.
- States: IDLE, ADD, DONE.
  - in_ready = (state==IDLE).
  - busy = (state==ADD).
  - out_valid = (state==DONE).
- IDLE: on in_valid && in_ready at edge E0, latch a, b, c_in into operand regs. Set carry reg=c_in, index=0, go to ADD. With no handshake, remain in IDLE.
- ADD, one nibble per cycle:
  - nibble k = a[4k+3:4k] + b[4k+3:4k] + carry reg, computed through the single 4-bit stage.
  - The 4-bit result is written into the partial-result reg at bits [4k+3:4k].
  - The stage carry-out is written to the carry reg.
  - index increments.
  - When k==NIB-1, go to DONE on the same edge. sum <= the full partial result including the final nibble. c_out <= final carry.
- Latency: out_valid rises exactly NIB cycles after E0 (4 cycles for WIDTH=16, 1 cycle for WIDTH=4).
- DONE: hold sum, c_out and out_valid stable until out_valid && out_ready. On that edge go to IDLE. out_valid drops; sum/c_out keep their value until the next completion.
- No back-to-back acceptance. in_valid is ignored in ADD and DONE, and new a/b values have no effect on the operation in flight.
- Minimum issue interval is NIB+2 cycles when out_ready is held high.
- Arithmetic: unsigned modulo 2^WIDTH. c_out is the true carry out of bit WIDTH-1. No wider adder may be inferred; all addition goes through the 4-bit stage.
- Reset mid-operation (ADD or DONE): abort on that edge. Return to the reset values; the result is discarded. The next accepted operation must not see a stale carry.
- Simultaneous reset and in_valid: reset wins, no acceptance.

Optional Feature:
NIBBLE_SUB_EN
- Defined: adds an input port op_sub (1 bit), latched with the operands on acceptance.
  - When latched op_sub=1: b is bitwise-inverted before entering the stage and the initial carry reg is forced to 1 (c_in ignored), giving a - b modulo 2^WIDTH.
  - c_out=1 means no borrow (a >= b).
  - Latency and handshakes are unchanged.
- Undefined: op_sub port is absent and the block adds only.

Test Plan:
- Reset, WIDTH=16, a=0x1234, b=0x0FED, c_in=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x2221, c_out=0; in_ready back to 1 one cycle after the result handshake.
- a=0xFFFF, b=0x0000, c_in=1 → sum=0x0000, c_out=1. Carry propagates through all 4 nibble steps.
- Backpressure: complete a=0x0001, b=0x0001 with out_ready=0 for 5 cycles while in_valid=1 with a=0xAAAA → sum=0x0002 held, out_valid=1, in_ready=0 throughout, 0xAAAA never accepted. Raise out_ready → IDLE next cycle.
- Reset asserted during ADD at index 2 → next cycle in_ready=1, out_valid=0, busy=0, sum=0. Then a=0x00FF, b=0x0001, c_in=0 → sum=0x0100, c_out=0.
- WIDTH=4 instance: a=0x9, b=0x8, c_in=0 → sum=0x1, c_out=1, out_valid 1 cycle after accept.
- With NIBBLE_SUB_EN, WIDTH=16: 0x1000 − 0x0001 → sum=0x0FFF, c_out=1. 0x0001 − 0x0002 → sum=0xFFFF, c_out=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple stage reused per nibble, LSB nibble first; result NIB cycles after accept, held until out_ready_i.
// Define NIBBLE_SUB_EN to add op_sub_i (a - b via inverted b and forced carry-in).
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_in_i,
`ifdef NIBBLE_SUB_EN
   input  logic             op_sub_i,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             c_out_o,
   output logic             busy_o
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int OW  = $clog2(WIDTH);

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
   end

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

   state_t           state_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
   logic             c_out_q, in_ready_q, busy_q, out_valid_q;
`ifdef NIBBLE_SUB_EN
   logic             sub_q;
`endif

   logic [OW-1:0]    off;
   logic [3:0]       x, y, nib_sum;
   logic             c, nib_cout;
   logic [WIDTH-1:0] part_d;

   // The only adder in the block: four full-adder cells on the selected nibble.
   always_comb begin
      off = OW'(idx_q) << 2;
      x   = a_q[off +: 4];
      y   = b_q[off +: 4];
`ifdef NIBBLE_SUB_EN
      if (sub_q) y = ~y;
`endif
      c       = carry_q;
      nib_sum = 4'd0;
      for (int i = 0; i < 4; i++) begin
         nib_sum[i] = x[i] ^ y[i] ^ c;
         c          = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      nib_cout         = c;
      part_d           = part_q;
      part_d[off +: 4] = nib_sum;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         part_q      <= '0;
         sum_q       <= '0;
         c_out_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef NIBBLE_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i) begin
                  a_q        <= a_i;
                  b_q        <= b_i;
                  idx_q      <= '0;
`ifdef NIBBLE_SUB_EN
                  sub_q      <= op_sub_i;
                  carry_q    <= op_sub_i ? 1'b1 : c_in_i;
`else
                  carry_q    <= c_in_i;
`endif
                  state_q    <= S_ADD;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_ADD: begin
               part_q  <= part_d;
               carry_q <= nib_cout;
               if (idx_q == IW'(NIB - 1)) begin
                  idx_q       <= '0;
                  sum_q       <= part_d;
                  c_out_q     <= nib_cout;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            S_DONE: begin
               if (out_ready_i) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign busy_o      = busy_q;
   assign out_valid_o = out_valid_q;
   assign sum_o       = sum_q;
   assign c_out_o     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: WIDTH=16 and WIDTH=4 instances, subtract vectors when NIBBLE_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        out_ready = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        c_in = 1'b0;
   logic        op_sub = 1'b0;
   logic        in_ready, out_valid, c_out, busy;
   logic [15:0] sum;

   logic        in_valid4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        c_in4 = 1'b0;
   logic        op_sub4 = 1'b0;
   logic        in_ready4, out_valid4, c_out4, busy4;
   logic [3:0]  sum4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .c_in_i(c_in),
`ifdef NIBBLE_SUB_EN
      .op_sub_i(op_sub),
`endif
      .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum), .c_out_o(c_out), .busy_o(busy)
   );

   nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
      .a_i(a4), .b_i(b4), .c_in_i(c_in4),
`ifdef NIBBLE_SUB_EN
      .op_sub_i(op_sub4),
`endif
      .out_valid_o(out_valid4), .out_ready_i(out_ready), .sum_o(sum4), .c_out_o(c_out4), .busy_o(busy4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation to the 16-bit instance and returns cycles from accept to out_valid (-1 on timeout).
   task automatic run_op16(input logic [15:0] av, input logic [15:0] bv, input logic cv, output int lat);
      a = av; b = bv; c_in = cv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if ({c_out, sum} !== 17'h0) begin errors++; $display("FAIL reset_sum: got %b/%h exp 0/0000", c_out, sum); end
      checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_w4: got rdy=%b vld=%b exp 1/0", in_ready4, out_valid4); end
   endtask

   task automatic test_idle_hold();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold: got rdy=%b busy=%b exp 1/0", in_ready, busy); end
      end
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      a = 16'h1234; b = 16'h0FED; c_in = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b rdy=%b exp 1/0", busy, in_ready); end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (out_valid) begin lat = i; break; end
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d exp 4", lat); end
      checks++; if (sum !== 16'h2221 || c_out !== 1'b0) begin errors++; $display("FAIL basic_sum: got %b/%h exp 0/2221", c_out, sum); end
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_return: got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_carry_chain();
      int lat;
      out_ready = 1'b1;
      run_op16(16'hFFFF, 16'h0000, 1'b1, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL carry_latency: got %0d exp 4", lat); end
      checks++; if (sum !== 16'h0000 || c_out !== 1'b1) begin errors++; $display("FAIL carry_sum: got %b/%h exp 1/0000", c_out, sum); end
      tick();
      run_op16(16'h8421, 16'h7BDE, 1'b0, lat);
      checks++; if (sum !== 16'hFFFF || c_out !== 1'b0) begin errors++; $display("FAIL nocarry_sum: got %b/%h exp 0/ffff", c_out, sum); end
      tick();
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      run_op16(16'h0001, 16'h0001, 1'b0, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d exp 4", lat); end
      a = 16'hAAAA; b = 16'hAAAA; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0002) begin
            errors++; $display("FAIL bp_hold: got vld=%b rdy=%b sum=%h exp 1/0/0002", out_valid, in_ready, sum);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_release: got rdy=%b vld=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
      end
      checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL bp_sum_kept: got %h exp 0002", sum); end
   endtask

   task automatic test_reset_mid();
      int lat;
      out_ready = 1'b1;
      a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_flags: got rdy=%b vld=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
      end
      checks++; if (sum !== 16'h0000 || c_out !== 1'b0) begin errors++; $display("FAIL midreset_sum: got %b/%h exp 0/0000", c_out, sum); end
      run_op16(16'h00FF, 16'h0001, 1'b0, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL midreset_latency: got %0d exp 4", lat); end
      checks++; if (sum !== 16'h0100 || c_out !== 1'b0) begin errors++; $display("FAIL midreset_next: got %b/%h exp 0/0100", c_out, sum); end
      tick();
   endtask

   task automatic test_reset_and_valid();
      a = 16'h0003; b = 16'h0004; c_in = 1'b0; in_valid = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_wins: got busy=%b rdy=%b exp 0/1", busy, in_ready); end
   endtask

   task automatic test_width4();
      int lat;
      out_ready = 1'b1;
      a4 = 4'h9; b4 = 4'h8; c_in4 = 1'b0; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (out_valid4) begin lat = i; break; end
      end
      checks++; if (lat != 1) begin errors++; $display("FAIL w4_latency: got %0d exp 1", lat); end
      checks++; if (sum4 !== 4'h1 || c_out4 !== 1'b1) begin errors++; $display("FAIL w4_sum: got %b/%h exp 1/1", c_out4, sum4); end
      tick();
      checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin errors++; $display("FAIL w4_return: got rdy=%b vld=%b exp 1/0", in_ready4, out_valid4); end
   endtask

`ifdef NIBBLE_SUB_EN
   task automatic test_subtract();
      int lat;
      out_ready = 1'b1;
      op_sub = 1'b1;
      run_op16(16'h1000, 16'h0001, 1'b0, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL sub_latency: got %0d exp 4", lat); end
      checks++; if (sum !== 16'h0FFF || c_out !== 1'b1) begin errors++; $display("FAIL sub_no_borrow: got %b/%h exp 1/0fff", c_out, sum); end
      tick();
      run_op16(16'h0001, 16'h0002, 1'b1, lat);
      checks++; if (sum !== 16'hFFFF || c_out !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %b/%h exp 0/ffff", c_out, sum); end
      tick();
      op_sub = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_idle_hold();
      test_basic();
      test_carry_chain();
      test_backpressure();
      test_reset_mid();
      test_reset_and_valid();
      test_width4();
`ifdef NIBBLE_SUB_EN
      test_subtract();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
